// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state type, prescale constants and frame bit-index helpers for the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam int START_IDX = 0;

    // Frame bit index of the parity bit (data bits occupy 1..data_width)
    function automatic int par_idx(input int data_width);
        return data_width + 1;
    endfunction

    // Frame bit index of the stop bit, which shifts by one when parity is present
    function automatic int stp_idx(input int data_width, input logic par_en);
        return data_width + 1 + int'(par_en);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame sequencer that runs the bit counter and strobes the sampler, deserializer and checkers
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRE_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx_in,
    input  logic [PRE_W-1:0] i_prescale,
    input  logic             i_par_en,
    input  logic             i_par_typ,
    input  logic [PRE_W-1:0] i_edge_cnt,
    input  logic [3:0]       i_bit_cnt,
    input  logic             i_strt_glitch,
    input  logic             i_par_err_in,
    input  logic             i_stp_err_in,
    output logic             o_cnt_en,
    output logic [PRE_W-1:0] o_cnt_prescale,
    output logic             o_par_typ_q,
    output logic             o_dat_samp_en,
    output logic             o_deser_en,
    output logic             o_strt_chk_en,
    output logic             o_par_chk_en,
    output logic             o_stp_chk_en,
    output logic             o_data_valid,
    output logic             o_par_err,
    output logic             o_stp_err,
    output logic             o_busy
);

    localparam logic [PRE_W-1:0] LP_ONE = PRE_W'(1);

    uart_rx_state_t   r_state;
    uart_rx_state_t   w_next;
    logic [PRE_W-1:0] r_cnt_prescale;
    logic             r_par_en;
    logic             r_par_typ;
    logic             r_par_flag;
    logic             r_data_valid;
    logic             r_par_err;
    logic             r_stp_err;
    logic             w_bit_end;
    logic             w_latch;

    assign w_bit_end = (i_edge_cnt == r_cnt_prescale - LP_ONE);
    // A frame starts from IDLE or directly from the stop-bit end of the previous frame
    assign w_latch   = (w_next == ST_START) && (r_state == ST_IDLE || r_state == ST_STOP);

    assign o_busy         = (r_state != ST_IDLE);
    assign o_cnt_en       = o_busy;
    assign o_dat_samp_en  = o_busy;
    assign o_cnt_prescale = r_cnt_prescale;
    assign o_par_typ_q    = r_par_typ;
    assign o_data_valid   = r_data_valid;
    assign o_par_err      = r_par_err;
    assign o_stp_err      = r_stp_err;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state and bit-end strobes, decoded from state and edge count
    always_comb begin
        w_next        = r_state;
        o_strt_chk_en = 1'b0;
        o_deser_en    = 1'b0;
        o_par_chk_en  = 1'b0;
        o_stp_chk_en  = 1'b0;
        case (r_state)
            ST_IDLE:   w_next = i_rx_in ? ST_IDLE : ST_START;
            ST_START: begin
                o_strt_chk_en = w_bit_end;
                if (w_bit_end) w_next = i_strt_glitch ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                o_deser_en = w_bit_end;
                if (w_bit_end && i_bit_cnt == 4'(DATA_WIDTH)) w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                o_par_chk_en = w_bit_end;
                if (w_bit_end) w_next = ST_STOP;
            end
            ST_STOP: begin
                o_stp_chk_en = w_bit_end;
                if (w_bit_end) w_next = i_rx_in ? ST_IDLE : ST_START;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Frame configuration is captured once per frame so mid-frame input changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_prescale <= PRE_W'(PRESCALE_8);
            r_par_en       <= 1'b0;
            r_par_typ      <= 1'b0;
        end else if (w_latch) begin
            r_cnt_prescale <= i_prescale;
            r_par_en       <= i_par_en;
            r_par_typ      <= i_par_typ;
        end
    end

    // Parity result is held from the parity bit until the stop bit reports the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              r_par_flag <= 1'b0;
        else if (w_latch)      r_par_flag <= 1'b0;
        else if (o_par_chk_en) r_par_flag <= i_par_err_in;
    end

    // One registered result pulse per completed frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= o_stp_chk_en && !i_stp_err_in && !r_par_flag;
            r_par_err    <= o_stp_chk_en && r_par_flag;
            r_stp_err    <= o_stp_chk_en && i_stp_err_in;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: frame-level reference schedule checked cycle by cycle against uart_rx_fsm
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct {
        int p;
        bit pe;
        bit pt;
        bit gl;
        bit perr;
        bit serr;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_rx_in = 1'b1;
    logic [PW-1:0] i_prescale = PW'(8);
    logic          i_par_en = 1'b0;
    logic          i_par_typ = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          i_strt_glitch = 1'b0;
    logic          i_par_err_in = 1'b0;
    logic          i_stp_err_in = 1'b0;
    logic          o_cnt_en, o_par_typ_q, o_dat_samp_en, o_deser_en, o_strt_chk_en;
    logic          o_par_chk_en, o_stp_chk_en, o_data_valid, o_par_err, o_stp_err, o_busy;
    logic [PW-1:0] o_cnt_prescale;

    int     cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     fT = -100000;
    frame_t cf = '{p:8, pe:0, pt:0, gl:0, perr:0, serr:0};
    frame_t nxt = '{p:8, pe:0, pt:0, gl:0, perr:0, serr:0};
    bit     chain = 0;
    bit     scramble = 1;
    logic [PW-1:0] cur_p = PW'(8);
    logic          cur_pt = 1'b0;
    logic [6:0]    ev[int];
    bit            bz[int];

    wire [16:0] obs = {o_busy, o_cnt_en, o_dat_samp_en, o_deser_en, o_strt_chk_en, o_par_chk_en,
                       o_stp_chk_en, o_data_valid, o_par_err, o_stp_err, o_cnt_prescale, o_par_typ_q};

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRE_W(PW)) dut (
        .clk(clk), .rst(rst), .i_rx_in(i_rx_in), .i_prescale(i_prescale), .i_par_en(i_par_en),
        .i_par_typ(i_par_typ), .i_edge_cnt(edge_cnt), .i_bit_cnt(bit_cnt),
        .i_strt_glitch(i_strt_glitch), .i_par_err_in(i_par_err_in), .i_stp_err_in(i_stp_err_in),
        .o_cnt_en(o_cnt_en), .o_cnt_prescale(o_cnt_prescale), .o_par_typ_q(o_par_typ_q),
        .o_dat_samp_en(o_dat_samp_en), .o_deser_en(o_deser_en), .o_strt_chk_en(o_strt_chk_en),
        .o_par_chk_en(o_par_chk_en), .o_stp_chk_en(o_stp_chk_en), .o_data_valid(o_data_valid),
        .o_par_err(o_par_err), .o_stp_err(o_stp_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sibling edge/bit counter: held at zero when idle, restarts its bit index at each frame boundary
    always @(posedge clk or negedge rst) begin
        if (!rst || !o_cnt_en || o_stp_chk_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == o_cnt_prescale - PW'(1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + PW'(1);
        end
    end

    function automatic int flen(input frame_t f);
        return f.gl ? f.p : (DW + int'(f.pe) + 2) * f.p;
    endfunction

    function automatic void mark(input int t, input logic [6:0] x);
        ev[t] = ev.exists(t) ? (ev[t] | x) : x;
    endfunction

    // Event bits {deser, strt, par, stp, dv, perr, serr}; bit j of the frame ends at T + (j+1)*p
    function automatic void plan(input int t0, input frame_t f);
        int n;
        n = flen(f);
        for (int c = 1; c <= n; c++) bz[t0 + c] = 1;
        mark(t0 + f.p, 7'b0100000);
        if (!f.gl) begin
            for (int j = 1; j <= DW; j++) mark(t0 + (j + 1) * f.p, 7'b1000000);
            if (f.pe) mark(t0 + (DW + 2) * f.p, 7'b0010000);
            mark(t0 + n, 7'b0001000);
            mark(t0 + n + 1, {4'b0000, !(f.pe && f.perr) && !f.serr, f.pe && f.perr, f.serr});
        end
    endfunction

    function automatic logic [16:0] expv(input int t);
        logic b;
        b = (bz.exists(t) != 0);
        return {b, b, b, (ev.exists(t) != 0) ? ev[t] : 7'd0, cur_p, cur_pt};
    endfunction

    function automatic frame_t rnd_frame();
        int     ps[6] = '{4, 5, 8, 12, 16, 32};
        frame_t f;
        f.p    = ps[$urandom_range(5)];
        f.pe   = 1'($urandom_range(1));
        f.pt   = 1'($urandom_range(1));
        f.gl   = ($urandom_range(3) == 0);
        f.perr = 1'($urandom_range(1));
        f.serr = ($urandom_range(3) == 0);
        return f;
    endfunction

    task automatic start_frame(input frame_t f);
        cf         = f;
        fT         = cyc;
        i_rx_in    = 1'b0;
        i_prescale = PW'(f.p);
        i_par_en   = f.pe;
        i_par_typ  = f.pt;
        plan(cyc, f);
    endtask

    // Advance to the middle of the next cycle and drive the line for the frame in flight
    task automatic tick();
        int c;
        @(negedge clk);
        c = cyc - fT;
        if (c == 1) begin
            cur_p         = PW'(cf.p);
            cur_pt        = cf.pt;
            i_strt_glitch = cf.gl;
            i_par_err_in  = cf.perr;
            i_stp_err_in  = cf.serr;
        end
        if (c >= 1 && c < flen(cf)) begin
            i_rx_in = cf.gl ? (c >= 3) : 1'($urandom_range(1));
            if (scramble) begin
                i_prescale = PW'(8 << $urandom_range(2));
                i_par_en   = 1'($urandom_range(1));
                i_par_typ  = 1'($urandom_range(1));
            end
        end else if (c == flen(cf) && chain && !cf.gl) begin
            chain = 0;
            start_frame(nxt);
        end else if (c >= 1) begin
            i_rx_in = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs !== expv(cyc)) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=%h", obs, expv(cyc));
        end
        rst = 1'b1;
        repeat (3) begin
            tick();
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
    endtask

    task automatic test_good_frame();
        int t0, nd, tdv;
        nd  = 0;
        tdv = -1;
        start_frame('{p:8, pe:1, pt:0, gl:0, perr:0, serr:0});
        t0 = cyc;
        while (cyc < t0 + 92) begin
            tick();
            nd += int'(o_deser_en);
            if (o_data_valid) tdv = cyc;
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL good_frame cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        n_cmp++;
        if (nd != 8) begin
            n_fail++;
            $display("FAIL good_deser_count got=%0d exp=8", nd);
        end
        n_cmp++;
        if (tdv != t0 + 89) begin
            n_fail++;
            $display("FAIL good_dv_cycle got=%0d exp=%0d", tdv - t0, 89);
        end
    endtask

    task automatic test_start_glitch();
        int t0, tb, nres, t1, ndv;
        tb   = -1;
        nres = 0;
        ndv  = 0;
        start_frame('{p:16, pe:0, pt:0, gl:1, perr:0, serr:0});
        t0 = cyc;
        while (cyc < t0 + 17) begin
            tick();
            if (!o_busy && tb < 0) tb = cyc;
            nres += int'(o_deser_en | o_data_valid | o_par_err | o_stp_err);
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        n_cmp++;
        if (tb != t0 + 17) begin
            n_fail++;
            $display("FAIL glitch_busy_fall got=%0d exp=17", tb - t0);
        end
        n_cmp++;
        if (nres != 0) begin
            n_fail++;
            $display("FAIL glitch_no_pulses got=%0d exp=0", nres);
        end
        start_frame('{p:8, pe:0, pt:1, gl:0, perr:0, serr:0});
        t1 = cyc;
        while (cyc < t1 + 83) begin
            tick();
            ndv += int'(o_data_valid);
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL post_glitch cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        n_cmp++;
        if (ndv != 1) begin
            n_fail++;
            $display("FAIL post_glitch_dv got=%0d exp=1", ndv);
        end
    endtask

    task automatic test_parity_b2b();
        int t0, npe, ndv, nidle;
        npe   = 0;
        ndv   = 0;
        nidle = 0;
        nxt   = '{p:8, pe:1, pt:1, gl:0, perr:0, serr:0};
        chain = 1;
        start_frame('{p:8, pe:1, pt:1, gl:0, perr:1, serr:0});
        t0 = cyc;
        while (cyc < t0 + 179) begin
            tick();
            npe += int'(o_par_err);
            ndv += int'(o_data_valid);
            if (cyc <= t0 + 176 && !o_busy) nidle++;
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL par_b2b cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        n_cmp++;
        if (npe != 1 || ndv != 1 || nidle != 0) begin
            n_fail++;
            $display("FAIL par_b2b_counts got par_err=%0d dv=%0d idle=%0d exp 1 1 0", npe, ndv, nidle);
        end
    endtask

    task automatic test_stop_err();
        int t0, tse, ndv;
        tse = -1;
        ndv = 0;
        start_frame('{p:32, pe:0, pt:0, gl:0, perr:1, serr:1});
        t0 = cyc;
        while (cyc < t0 + 324) begin
            tick();
            if (o_stp_err) tse = cyc;
            ndv += int'(o_data_valid);
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL stop_err cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        n_cmp++;
        if (tse != t0 + 321 || ndv != 0) begin
            n_fail++;
            $display("FAIL stop_err_pulse got at=%0d dv=%0d exp at=321 dv=0", tse - t0, ndv);
        end
    endtask

    task automatic test_config_hold();
        int t0;
        scramble = 0;
        start_frame('{p:8, pe:1, pt:0, gl:0, perr:0, serr:0});
        t0 = cyc;
        while (cyc < t0 + 92) begin
            tick();
            if (cyc == t0 + 3) begin
                i_prescale = PW'(16);
                i_par_en   = 1'b0;
                i_par_typ  = 1'b1;
            end
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL config_hold cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        n_cmp++;
        if (o_cnt_prescale !== PW'(8)) begin
            n_fail++;
            $display("FAIL config_prescale got=%0d exp=8", o_cnt_prescale);
        end
        scramble = 1;
    endtask

    task automatic test_reset_mid();
        int t0;
        start_frame('{p:16, pe:1, pt:1, gl:0, perr:0, serr:0});
        t0 = cyc;
        while (cyc < t0 + 60) begin
            tick();
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {10'd0, PW'(8), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=%h", obs, {10'd0, PW'(8), 1'b0});
        end
        ev.delete();
        bz.delete();
        cur_p   = PW'(8);
        cur_pt  = 1'b0;
        fT      = -100000;
        i_rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 200) begin
            tick();
            n_cmp++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs, expv(cyc));
            end
        end
    endtask

    task automatic test_random();
        int t0, len;
        bit ch;
        start_frame(rnd_frame());
        for (int k = 0; k < 24; k++) begin
            t0  = fT;
            len = flen(cf);
            ch  = !cf.gl && k < 23 && ($urandom_range(1) == 1);
            if (ch) begin
                nxt   = rnd_frame();
                chain = 1;
            end
            while (cyc < t0 + len + (ch ? 0 : 3)) begin
                tick();
                n_cmp++;
                if (obs !== expv(cyc)) begin
                    n_fail++;
                    $display("FAIL random f=%0d cyc=%0d got=%h exp=%h", k, cyc, obs, expv(cyc));
                end
            end
            if (!ch && k < 23) start_frame(rnd_frame());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_start_glitch();
        test_parity_b2b();
        test_stop_err();
        test_config_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame-sequencing controller for the UART receiver. It detects the start-bit falling edge and runs the shared edge/bit counter. It strobes the data sampler, deserializer and start/parity/stop checkers at the right oversampling edges, and produces a one-cycle `data_valid` or error pulse per frame. It sits in `uart_rx` between the synchronized `rx_in` line and the counter/sampler/checker datapath, in the UART_RX clock domain.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; range 5..8.
- `PRE_W`, 6: width of the prescale and edge counter, sized to hold 32.
- `clk` input 1: UART RX clock, oversampled.
- `rst` input 1: asynchronous, active-low reset.
- `rx_in` input 1: serial line, already synchronized, idle high.
- `prescale` input PRE_W: oversampling ratio; legal values 8, 16, 32.
- `par_en` input 1: 1 means a parity bit is present.
- `par_typ` input 1: 0 = even, 1 = odd.
- `edge_cnt` input PRE_W: from the counter; 0..prescale-1 within a bit.
- `bit_cnt` input 4: from the counter; frame bit index, start bit = 0.
- `strt_glitch`, `par_err_in`, `stp_err_in` input 1 each: combinational checker results, valid in the same cycle as the matching enable.
- `cnt_en` output 1: counter run. When low, the counter holds `edge_cnt` = 0 and `bit_cnt` = 0.
- `cnt_prescale` output PRE_W: latched prescale driven to the counter and sampler.
- `par_typ_q` output 1: latched parity type driven to the parity checker.
- `dat_samp_en` output 1: sampler enable.
- `deser_en`, `strt_chk_en`, `par_chk_en`, `stp_chk_en` output 1 each: single-cycle strobes.
- `data_valid`, `par_err`, `stp_err` output 1 each: registered single-cycle frame result pulses.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- A "bit end" is a cycle in which `edge_cnt` == `cnt_prescale`-1.
- IDLE
  - `rx_in` == 0 moves to START.
  - On that transition, latch `prescale` into `cnt_prescale`, and latch `par_en` and `par_typ`.
  - Latched configuration is held until the next return to IDLE; input changes mid-frame have no effect.
- START
  - At bit end: pulse `strt_chk_en`.
  - If `strt_glitch` is 1, go to IDLE with no result pulse.
  - Otherwise go to DATA.
- DATA
  - `deser_en` pulses at each bit end.
  - At the bit end with `bit_cnt` == DATA_WIDTH: go to PARITY if the latched `par_en` is 1, else to STOP.
- PARITY
  - At bit end: pulse `par_chk_en` and capture `par_err_in` into an internal flag.
  - Then go to STOP.
- STOP
  - At bit end: pulse `stp_chk_en`.
  - Next cycle outputs:
    - `stp_err` = `stp_err_in`.
    - `par_err` = the captured parity flag.
    - `data_valid` = 1 only if both are 0.
  - State goes to IDLE, or directly to START if `rx_in` == 0 in that cycle (back-to-back frames); direct re-entry re-latches configuration.
- Enable outputs
  - `cnt_en` and `dat_samp_en` are Moore outputs, high in all states except IDLE.
  - All strobes are decoded from state and `edge_cnt`.
- Reset, asynchronous, including mid-frame:
  - State goes to IDLE.
  - All outputs go to 0, and `cnt_prescale` goes to 8.
  - Any frame in progress is discarded without a pulse.

## Timing
- Let the first IDLE cycle sampling `rx_in` = 0 be cycle T. START is entered at T+1 with `edge_cnt` = 0.
- Frame of N bits, where N = 1 + DATA_WIDTH + `par_en` + 1:
  - The stop bit end is at cycle T + N·`cnt_prescale`.
  - Result pulses appear one cycle later.
- Strobes are exactly one cycle wide. At most one of `data_valid` / `par_err` / `stp_err` … except that `par_err` and `stp_err` may both be high together.
- A start glitch returns the block to IDLE at T + `cnt_prescale` + 1 (the state transition at the start-bit end; `busy` drops that cycle). A new falling edge is accepted from the next cycle.
- `prescale` values other than 8, 16 and 32 but ≥ 4 still sequence correctly; values below 4 are unsupported.

## Structure
- Shared package `uart_rx_pkg`:
  - `uart_rx_state_t` state enum.
  - `PRESCALE_8/16/32` constants.
  - `START_IDX` = 0 and the parity/stop index helpers as functions of DATA_WIDTH.
- No sub-module. The edge/bit counter, sampler and checkers are sibling instances in `uart_rx`.

## Test plan
- **Good frame:** prescale 8, `par_en` 1, even parity, byte 0xA5 with parity bit 0.
  - `data_valid` is high for one cycle at T+89.
  - 8 `deser_en` pulses.
  - `par_err` and `stp_err` stay 0.
- **Start glitch:** prescale 16, `rx_in` low for 3 cycles then high, `strt_glitch` = 1.
  - Return to IDLE.
  - `busy` falls at T+17.
  - No result pulses and no `deser_en`.
- **Parity error plus back-to-back frames:** prescale 8, odd parity, wrong parity bit, second frame starting immediately after the stop bit end.
  - `par_err` pulse.
  - Second frame START entered directly with no IDLE cycle.
  - Second frame gives `data_valid`.
- **Stop error:** prescale 32, `par_en` 0, `stp_err_in` = 1.
  - `stp_err` pulse at T+321.
  - `data_valid` stays 0.
- **Config change and reset:**
  - Change `prescale` from 8 to 16 mid-frame: `cnt_prescale` stays 8 until the frame completes.
  - Assert `rst` in DATA: all outputs 0 and `busy` 0 immediately, with no result pulse after release.
